// File: rtl/dp_pkg.sv
// Shared opcode encodings and flag bit positions for the pipelined datapath.
// Pure definitions; no logic, no latency.
package dp_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_MOV = 3'b110;
    localparam logic [2:0] OP_INC = 3'b111;

    // Flag vector layout is {o, z, n}
    localparam int FLAG_N = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_O = 2;
    localparam int NFLAGS = 3;

endpackage

// File: rtl/rf_2r1w.sv
// 2^M x N register file: two asynchronous reads, one synchronous write, all entries cleared on reset.
// Reads are combinational; write lands at the rising edge when we is high; no backpressure.
module rf_2r1w #(
    parameter int M = 3,
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [M-1:0] raddr_a,
    output logic [N-1:0] rdata_a,
    input  logic [M-1:0] raddr_b,
    output logic [N-1:0] rdata_b,
    input  logic         we,
    input  logic [M-1:0] waddr,
    input  logic [N-1:0] wdata
);

    logic [N-1:0] mem_q [2**M];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2**M; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_a = mem_q[raddr_a];
    assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/datapath_pipe.sv
// Register file + operand mux + ALU feeding one registered execute/writeback stage; result 1 cycle after issue.
// Issue stalls while a result is held (out_ready low) or, without forwarding, on a RAW hazard.
module datapath_pipe #(
    parameter int M      = 3,
    parameter int N      = 8,
    parameter bit FWD_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [M-1:0] ra,
    input  logic [M-1:0] rb,
    input  logic [M-1:0] waddr,
    input  logic         write,
    input  logic         ie,
    input  logic         bypassa,
    input  logic [N-1:0] din,
    input  logic [N-1:0] offset,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] dout,
    output logic         o_flag,
    output logic         z_flag,
    output logic         n_flag
);
    import dp_pkg::*;

    // Returns {overflow, result}
    function automatic logic [N:0] alu_f(input logic [2:0] op_f,
                                         input logic [N-1:0] a,
                                         input logic [N-1:0] b);
        logic [N-1:0] r;
        logic         ovf;
        r   = '0;
        ovf = 1'b0;
        case (op_f)
            OP_ADD: begin
                r   = a + b;
                ovf = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
            end
            OP_SUB: begin
                r   = a - b;
                ovf = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
            end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_NOT: r = ~a;
            OP_MOV: r = a;
            OP_INC: begin
                r   = a + {{(N-1){1'b0}}, 1'b1};
                ovf = !a[N-1] && r[N-1];
            end
            default: r = a;
        endcase
        return {ovf, r};
    endfunction

    logic              s2_valid_q;
    logic              s2_write_q;
    logic [M-1:0]      s2_waddr_q;
    logic [N-1:0]      dout_q;
    logic [NFLAGS-1:0] flags_q;

    logic [N-1:0]      rf_a;
    logic [N-1:0]      rf_b;
    logic              hit_a;
    logic              hit_b;
    logic              hazard_stall;
    logic              accept;
    logic              retire;
    logic [N-1:0]      opa;
    logic [N-1:0]      opb;
    logic [N:0]        alu_out;
    logic [N-1:0]      res_d;
    logic [NFLAGS-1:0] flags_d;

    rf_2r1w #(.M(M), .N(N)) u_rf (
        .clk     (clk),
        .rst     (rst),
        .raddr_a (ra),
        .rdata_a (rf_a),
        .raddr_b (rb),
        .rdata_b (rf_b),
        .we      (retire && s2_write_q),
        .waddr   (s2_waddr_q),
        .wdata   (dout_q)
    );

    // A pending write to an operand's address wins over the (not yet written) register file
    assign hit_a = s2_valid_q && s2_write_q && (s2_waddr_q == ra);
    assign hit_b = s2_valid_q && s2_write_q && (s2_waddr_q == rb);

    assign hazard_stall = FWD_EN ? 1'b0 : ((hit_a && !bypassa) || hit_b);

    assign in_ready = (!s2_valid_q || out_ready) && !hazard_stall;
    assign accept   = in_valid && in_ready;
    assign retire   = s2_valid_q && out_ready;

    assign opa = bypassa ? offset : (hit_a ? dout_q : rf_a);
    assign opb = hit_b ? dout_q : rf_b;

    assign alu_out = alu_f(op, opa, opb);
    assign res_d   = ie ? din : alu_out[N-1:0];

    always_comb begin
        flags_d         = '0;
        flags_d[FLAG_O] = ie ? 1'b0 : alu_out[N];
        flags_d[FLAG_Z] = (res_d == '0);
        flags_d[FLAG_N] = res_d[N-1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid_q <= 1'b0;
            s2_write_q <= 1'b0;
            s2_waddr_q <= '0;
            dout_q     <= '0;
            flags_q    <= '0;
        end else if (accept) begin
            s2_valid_q <= 1'b1;
            s2_write_q <= write;
            s2_waddr_q <= waddr;
            dout_q     <= res_d;
            flags_q    <= flags_d;
        end else if (retire) begin
            s2_valid_q <= 1'b0;
        end
    end

    assign out_valid = s2_valid_q;
    assign dout      = dout_q;
    assign o_flag    = flags_q[FLAG_O];
    assign z_flag    = flags_q[FLAG_Z];
    assign n_flag    = flags_q[FLAG_N];

endmodule

// File: tb/tb_datapath_pipe.sv
// Bench for datapath_pipe: vector table through a result scoreboard, plus hand sequences for
// the no-forwarding stall, backpressure and reset-during-stall cases.
module tb_datapath_pipe;
    import dp_pkg::*;

    localparam int M = 3;
    localparam int N = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid, in_ready, write, ie, bypassa, out_valid, out_ready;
    logic [2:0]   op;
    logic [M-1:0] ra, rb, waddr;
    logic [N-1:0] din, offset, dout;
    logic         o_flag, z_flag, n_flag;

    logic         f0_in_valid, f0_in_ready, f0_write, f0_ie, f0_bypassa, f0_out_valid, f0_out_ready;
    logic [2:0]   f0_op;
    logic [M-1:0] f0_ra, f0_rb, f0_waddr;
    logic [N-1:0] f0_din, f0_offset, f0_dout;
    logic         f0_o_flag, f0_z_flag, f0_n_flag;

    datapath_pipe #(.M(M), .N(N), .FWD_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .ra(ra), .rb(rb), .waddr(waddr), .write(write), .ie(ie), .bypassa(bypassa),
        .din(din), .offset(offset), .out_valid(out_valid), .out_ready(out_ready),
        .dout(dout), .o_flag(o_flag), .z_flag(z_flag), .n_flag(n_flag)
    );

    datapath_pipe #(.M(M), .N(N), .FWD_EN(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(f0_in_valid), .in_ready(f0_in_ready), .op(f0_op),
        .ra(f0_ra), .rb(f0_rb), .waddr(f0_waddr), .write(f0_write), .ie(f0_ie),
        .bypassa(f0_bypassa), .din(f0_din), .offset(f0_offset), .out_valid(f0_out_valid),
        .out_ready(f0_out_ready), .dout(f0_dout), .o_flag(f0_o_flag), .z_flag(f0_z_flag),
        .n_flag(f0_n_flag)
    );

    typedef struct {
        logic [2:0]   op;
        logic [M-1:0] ra, rb, wa;
        logic         wr, ie, byp;
        logic [N-1:0] din, off;
        logic [N-1:0] exp_d;
        logic [2:0]   exp_f;   // {o, z, n}
    } vec_t;

    typedef struct {
        logic [N-1:0] d;
        logic [2:0]   f;
    } exp_t;

    vec_t tbl[16];
    vec_t hv;
    exp_t sb_q[$];
    exp_t sb_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   ready_drops = 0;
    int   stalls;
    bit   table_phase = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Scoreboard: every retiring result is compared against the oldest expected entry
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_unexpected: got result 0x%0h, required none", dout);
            end else begin
                sb_e = sb_q.pop_front();
                check("sb_dout", dout, sb_e.d);
                check("sb_flags", {o_flag, z_flag, n_flag}, sb_e.f);
            end
        end
    end

    always @(negedge clk) begin
        if (table_phase && in_valid && !in_ready) ready_drops++;
    end

    task automatic drive(input vec_t v);
        op = v.op; ra = v.ra; rb = v.rb; waddr = v.wa; write = v.wr;
        ie = v.ie; bypassa = v.byp; din = v.din; offset = v.off;
        in_valid = 1'b1;
    endtask

    task automatic issue(input vec_t v);
        drive(v);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL issue_timeout: got in_ready=0, required 1");
        end else begin
            sb_q.push_back('{d: v.exp_d, f: v.exp_f});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish before timeout");
        $fatal(1);
    end

    initial begin
        //        op      ra rb wa wr ie byp din    off    exp_d  exp_f
        tbl[0]  = '{OP_MOV, 0, 0, 1, 1, 1, 0, 8'h7F, 8'h00, 8'h7F, 3'b000};
        tbl[1]  = '{OP_ADD, 1, 1, 2, 1, 0, 0, 8'h00, 8'h00, 8'hFE, 3'b101};
        tbl[2]  = '{OP_SUB, 2, 2, 5, 1, 0, 0, 8'h00, 8'h00, 8'h00, 3'b010};
        tbl[3]  = '{OP_MOV, 0, 0, 3, 1, 1, 0, 8'h03, 8'h00, 8'h03, 3'b000};
        tbl[4]  = '{OP_ADD, 0, 3, 0, 0, 0, 1, 8'h00, 8'h05, 8'h08, 3'b000};
        tbl[5]  = '{OP_AND, 1, 2, 0, 0, 0, 0, 8'h00, 8'h00, 8'h7E, 3'b000};
        tbl[6]  = '{OP_OR,  1, 3, 0, 0, 0, 0, 8'h00, 8'h00, 8'h7F, 3'b000};
        tbl[7]  = '{OP_XOR, 2, 3, 0, 0, 0, 0, 8'h00, 8'h00, 8'hFD, 3'b001};
        tbl[8]  = '{OP_NOT, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h80, 3'b001};
        tbl[9]  = '{OP_MOV, 5, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 3'b010};
        tbl[10] = '{OP_INC, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h80, 3'b101};
        tbl[11] = '{OP_SUB, 0, 1, 0, 0, 0, 1, 8'h00, 8'h80, 8'h01, 3'b100};
        tbl[12] = '{OP_INC, 0, 0, 0, 0, 0, 1, 8'h00, 8'hFF, 8'h00, 3'b010};
        tbl[13] = '{OP_MOV, 0, 0, 0, 1, 1, 0, 8'h11, 8'h00, 8'h11, 3'b000};
        tbl[14] = '{OP_MOV, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h11, 3'b000};
        tbl[15] = '{OP_ADD, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h22, 3'b000};

        rst = 1'b0;
        in_valid = 0; op = 0; ra = 0; rb = 0; waddr = 0; write = 0; ie = 0; bypassa = 0;
        din = 0; offset = 0; out_ready = 1'b1;
        f0_in_valid = 0; f0_op = 0; f0_ra = 0; f0_rb = 0; f0_waddr = 0; f0_write = 0;
        f0_ie = 0; f0_bypassa = 0; f0_din = 0; f0_offset = 0; f0_out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_dout", dout, 8'h00);
        check("rst_flags", {o_flag, z_flag, n_flag}, 3'b000);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);

        // No-forwarding variant: load r1 then dependent ADD must stall exactly one cycle
        @(posedge clk); #1;
        f0_op = OP_MOV; f0_waddr = 1; f0_write = 1; f0_ie = 1; f0_din = 8'h7F; f0_in_valid = 1;
        @(negedge clk);
        check("f0_load_rdy", f0_in_ready, 1'b1);
        @(posedge clk); #1;
        f0_op = OP_ADD; f0_ra = 1; f0_rb = 1; f0_waddr = 2; f0_ie = 0;
        @(negedge clk);
        check("f0_load_dout", f0_dout, 8'h7F);
        stalls = 0;
        while (!f0_in_ready && stalls < 20) begin
            stalls++;
            @(negedge clk);
        end
        check("f0_stall_cycles", stalls, 1);
        @(posedge clk); #1;
        f0_in_valid = 0;
        @(negedge clk);
        check("f0_add_dout", f0_dout, 8'hFE);
        check("f0_add_flags", {f0_o_flag, f0_z_flag, f0_n_flag}, 3'b101);

        // Forwarding variant: table streamed back to back
        @(posedge clk); #1;
        table_phase = 1'b1;
        for (int i = 0; i < 16; i++) issue(tbl[i]);
        table_phase = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("tbl_ready_drops", ready_drops, 0);
        check("tbl_sb_drained", sb_q.size(), 0);

        // Backpressure: load r4=0xAA held for 3 cycles with a dependent MOV waiting
        out_ready = 1'b0;
        hv = '{OP_MOV, 0, 0, 4, 1, 1, 0, 8'hAA, 8'h00, 8'hAA, 3'b001};
        drive(hv);
        @(negedge clk);
        check("bp_accept_rdy", in_ready, 1'b1);
        sb_q.push_back('{d: 8'hAA, f: 3'b001});
        @(posedge clk); #1;
        hv = '{OP_MOV, 4, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'hAA, 3'b001};
        drive(hv);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_dout", dout, 8'hAA);
            check("bp_flags", {o_flag, z_flag, n_flag}, 3'b001);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_r4_held", u_dut.u_rf.mem_q[4], 8'h00);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_rdy", in_ready, 1'b1);
        sb_q.push_back('{d: 8'hAA, f: 3'b001});
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_r4_written", u_dut.u_rf.mem_q[4], 8'hAA);
        repeat (3) @(posedge clk);
        #1;
        check("bp_sb_drained", sb_q.size(), 0);

        // Reset during a stall discards the pending write to r4
        out_ready = 1'b0;
        hv = '{OP_MOV, 0, 0, 4, 1, 1, 0, 8'h33, 8'h00, 8'h33, 3'b000};
        drive(hv);
        @(negedge clk);
        check("rk_accept_rdy", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("rk_pending", out_valid, 1'b1);
        rst = 1'b0;
        #2;
        check("rk_r4", u_dut.u_rf.mem_q[4], 8'h00);
        check("rk_out_valid", out_valid, 1'b0);
        check("rk_dout", dout, 8'h00);
        @(posedge clk); #1;
        rst = 1'b1;
        out_ready = 1'b1;
        issue('{OP_MOV, 4, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 3'b010});
        issue('{OP_MOV, 6, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 3'b010});
        repeat (3) @(posedge clk);
        #1;
        check("rk_sb_drained", sb_q.size(), 0);
        check("rk_r4_final", u_dut.u_rf.mem_q[4], 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/datapath_pipe.md
Name: datapath_pipe

Overview:
Parametrised, pipelined successor to the single-cycle datapath. It holds a 2^M x N register file (two reads, one write), an operand mux with immediate bypass, an ALU, and one registered execute/writeback stage. A valid/ready handshake is added on both issue and result sides, with result forwarding, so the block can sit behind a sequencer or FIFO that applies backpressure.

Parameters:
M, 3, register address width; the register file has 2^M entries
N, 8, data width of registers, din, offset and dout
FWD_EN, 1, 1 = forward the stage-2 result to stage-1 operands; 0 = stall issue on a RAW hazard instead

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  issue bundle valid
in_ready  output  1  block can accept the bundle this cycle
op  input  3  ALU opcode
ra  input  M  operand A register address
rb  input  M  operand B register address
waddr  input  M  destination register
write  input  1  write the result to waddr at retire
ie  input  1  1 = result is din (load); 0 = ALU result
bypassa  input  1  1 = operand A is offset instead of R[ra]
din  input  N  external load data
offset  input  N  immediate operand
out_valid  output  1  dout and flags hold a pending result
out_ready  input  1  consumer accepts the result
dout  output  N  stage-2 result
o_flag  output  1  signed overflow of the stage-2 result
z_flag  output  1  stage-2 result == 0
n_flag  output  1  stage-2 result MSB

Behaviour:
- Reset (rst=0, asynchronous): all register-file entries = 0; s2_valid = 0; dout = 0; o/z/n = 0. On release, in_ready = 1.
- Issue: a bundle is accepted when in_valid && in_ready.
- in_ready = (!s2_valid || out_ready) && !hazard_stall. hazard_stall is always 0 when FWD_EN=1.
- Stage 1 (combinational, the acceptance cycle):
  - A = bypassa ? offset : fwdR[ra]; B = fwdR[rb].
  - fwdR[x] = stage-2 result if s2_valid && s2_write && s2_waddr == x; otherwise R[x].
  - With FWD_EN=0, hazard_stall = s2_valid && s2_write && a matching, non-bypassed operand address.
- ALU ops, mod 2^N:
  - 000 ADD A+B; 001 SUB A-B; 010 AND; 011 OR; 100 XOR; 101 NOT A; 110 MOV A; 111 INC A+1.
  - Overflow uses two's-complement sign rules for ADD, SUB and INC; it is 0 for all other ops and for loads.
- Result = ie ? din : ALU. Z and N are computed from the result in every case.
- Stage 2: on acceptance, the result, flags, waddr and write are registered and s2_valid = 1. Latency: result appears on dout exactly 1 cycle after acceptance.
- Retire: occurs on out_valid && out_ready.
  - The register file is written (if s2_write) at that edge.
  - If a new bundle is accepted in the same cycle, stage 2 reloads; otherwise s2_valid = 0.
- Output rules:
  - out_valid = s2_valid.
  - dout and flags hold stable while out_valid && !out_ready.
  - With no valid result, dout and flags keep their last values. X is never driven.
- Simultaneous retire write and read of the same address: forwarding supplies the new value, so there is no stale read.
- With FWD_EN=0, the same case is avoided by the stall.
- A write to any address, including 0, is allowed; there is no hardwired-zero register.
- A reset asserted mid-stall discards the pending result without writing the register file.

Decomposition:
- Shared package dp_pkg holds the opcode localparams (OP_ADD..OP_INC) and the flag bit indices.
- Sub-module rf_2r1w holds the register file: parameters M and N; ports clk, rst, 2 asynchronous read ports, 1 synchronous write port with enable.
- The ALU stays inline in datapath_pipe as a combinational function.

Test Plan:
- Reset: hold rst=0 mid-traffic, then release -> dout=0x00, flags 000, out_valid=0, in_ready=1; a MOV from any register returns 0x00.
- Back-to-back forwarding (N=8, FWD_EN=1):
  - Load ie=1, din=0x7F to r1, then next cycle ADD ra=rb=r1 to r2.
  - Required: dout 0x7F, then 0xFE; o=1, n=1, z=0; in_ready never drops.
- Same sequence with FWD_EN=0 -> in_ready=0 for exactly one cycle; final dout=0xFE.
- Zero flag: SUB ra=rb=r2 (0xFE) -> dout=0x00, z=1, n=0, o=0.
- Immediate operand: bypassa=1, offset=0x05, rb=r3 holding 0x03, op ADD -> dout=0x08.
- Backpressure: out_ready=0 for 3 cycles after a result targeting r4=0xAA.
  - Required: dout and flags stable, in_ready=0, r4 unchanged.
  - When out_ready=1, r4=0xAA one edge later.
  - A pending result killed by rst=0 leaves r4 = 0.
